ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch front end for the `riscv` core. It generates sequential PCs, drives the instruction bus master handshake, and tracks in-order outstanding requests. Returned instructions are buffered with their PC in a small queue that feeds decode. A redirect (branch/jump/trap) from the core flushes the queue, discards stale in-flight responses and restarts fetch at the new PC.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 4: queue entries, power of two, ≥2. Also the cap on in-flight plus buffered instructions.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `iBus_cmd_valid`  out  1  fetch request valid.
- `iBus_cmd_ready`  in  1  bus accepts the request this cycle.
- `iBus_cmd_payload_pc`  out  32  fetch address, word aligned.
- `iBus_rsp_ready`  in  1  response valid strobe; in order; one per cycle max.
- `iBus_rsp_err`  in  1  bus error for this response.
- `iBus_rsp_inst`  in  32  returned instruction word.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored, treated as 0.
- `out_valid`  out  1  head entry available to decode.
- `out_ready`  in  1  decode consumes head entry.
- `out_pc`  out  32  PC of the head entry.
- `out_inst`  out  32  instruction of the head entry.
- `out_err`  out  1  head entry carries a bus error.

## Operation
- Entry-per-request queue with three pointers: `tail` allocates at command accept and stores the PC; `fill` writes inst/err on response; `head` pops. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `count` = allocated entries, 0..DEPTH.
- Command FSM:
  - **IDLE**: assert `cmd_valid` with `fetch_pc` when `count < DEPTH` and not halted → **REQ**.
  - **REQ**: `cmd_valid`=1. `payload_pc` must stay stable until `cmd_ready`.
    - On accept: allocate an entry and set `fetch_pc += 4` (wraps at 2^32).
    - If space remains, issue the next command back to back. Otherwise → IDLE.
- `out_valid` = head entry allocated and filled. Pop on `out_valid && out_ready`.
- Error: a response with `iBus_rsp_err=1` sets `halted`. No new commands issue until a redirect. Already accepted commands still complete and are queued. Entry data is passed through unchanged, and `out_err` is flagged.
- Redirect cycle:
  - Empty the queue: head=fill=tail, count=0.
  - `fetch_pc ← {redirect_pc[31:2],2'b00}` and clear `halted`.
  - `discard ← number of accepted-but-unreturned commands`.
- A command that is valid but not yet accepted at redirect stays presented with its old PC. Its acceptance increments `discard`, and the redirect PC is issued after it.
- While `discard>0`, each response decrements `discard` and is dropped. It writes no entry and does not set `halted`.
- Simultaneous events in one cycle:
  - Redirect + response: the response is dropped and counted into `discard`.
  - Redirect + command accept: that command is counted into `discard`.
  - Redirect + pop: the pop is ignored.
  - Accept + pop with `count==DEPTH`: the new allocation is legal in the same cycle.
- `discard` width is clog2(DEPTH+1).
- A response arriving with nothing outstanding is a protocol violation. It is covered by a simulation assertion and otherwise ignored.

## Timing
- Reset values:
  - `iBus_cmd_valid`=0, `iBus_cmd_payload_pc`=RESET_PC.
  - `out_valid`=0, `out_pc`=0, `out_inst`=0, `out_err`=0.
  - FSM=IDLE, `count`=0, `discard`=0, `halted`=0.
- First `cmd_valid` appears on the first edge after `rst` deasserts.
- Response to `out_valid`: 1 cycle (registered fill), provided the entry is at head.
- Redirect to new-PC command: valid on the next cycle, unless an unaccepted command is pending, in which case it follows that command's acceptance.
- Throughput: 1 instruction/cycle when `DEPTH ≥ bus latency + 1` and decode is always ready.
- Asserting `rst` mid-transfer abandons all state immediately. The bus must be reset together with this block.

## Structure
- Shared package `riscv_pkg`: `XLEN`=32, `inst_t` (logic [31:0]), `addr_t`, `fetch_entry_t` struct {pc, inst, err}, `RESET_PC_DEFAULT`.
- A single module with an inline entry array. No sub-module is required.
- `fetch_entry_t` is reused by the decode stage.

## Test plan
- Reset with DEPTH=4, response latency 1, `out_ready`=1 → commands issue to PCs 0x0, 0x4, 0x8, …. Outputs appear in order, one per cycle, with `out_pc` matching each command.
- `out_ready`=0 with zero-latency acceptance → exactly 4 commands accepted, then `cmd_valid` stays low. One pop → exactly one more command, PC 0x10.
- `cmd_ready` held low for 5 cycles → `payload_pc` stays stable at 0x0 and `cmd_valid` stays high throughout.
- Redirect to 0x100 with 3 responses outstanding → those 3 responses are dropped and `out_valid` stays 0. The first output is pc=0x100 and the queue is empty after the redirect.
- Response with `iBus_rsp_err`=1 for PC 0x8 → `out_err`=1 on that entry and no further commands issue. Redirect to 0x40 → fetch resumes at 0x40.
- Redirect in the same cycle as a command accept and a response → both are discarded and `discard` ends at the correct count. No stale PC ever reaches the output.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the riscv core front end.
//   XLEN             - architectural register / address width
//   inst_t, addr_t   - instruction word and byte address
//   fetch_entry_t    - one fetched instruction with its PC and bus error flag
//                      (also consumed by the decode stage)
//   fetch_state_e    - instruction bus command FSM states
//   align_word()     - force an address onto a word boundary
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] inst_t;
   typedef logic [XLEN-1:0] addr_t;

   typedef struct packed {
      addr_t pc;
      inst_t inst;
      logic  err;
   } fetch_entry_t;

   localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_REQ  = 1'b1
   } fetch_state_e;

   function automatic addr_t align_word(input addr_t a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: sequential PC generation, instruction bus
// command handshake, in-order tracking of outstanding requests, and a small
// entry-per-request queue of {pc, inst, err} feeding decode. A redirect
// flushes the queue and restarts fetch; responses still in flight for
// flushed requests are counted and dropped.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   iBus_cmd_valid/ready     fetch command handshake
//   iBus_cmd_payload_pc      fetch address (word aligned, stable while pending)
//   iBus_rsp_ready           response strobe (in order, <= 1 per cycle)
//   iBus_rsp_err/inst        response error flag and instruction word
//   redirect_valid/pc        flush and restart fetch at redirect_pc
//   out_valid/ready          head entry handshake towards decode
//   out_pc/inst/err          head entry contents
module ifetch_queue
   import riscv_pkg::*;
#(
   parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,

   output logic        iBus_cmd_valid,
   input  logic        iBus_cmd_ready,
   output logic [31:0] iBus_cmd_payload_pc,

   input  logic        iBus_rsp_ready,
   input  logic        iBus_rsp_err,
   input  logic [31:0] iBus_rsp_inst,

   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,

   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   fetch_state_e state_q, state_d;
   addr_t        cmd_pc_q, cmd_pc_d;      // address currently presented on the bus
   addr_t        fetch_pc_q, fetch_pc_d;  // address of the next command to present
   ptr_t         head_q, head_d;
   ptr_t         fill_q, fill_d;
   ptr_t         tail_q, tail_d;
   cnt_t         count_q, count_d;        // allocated entries (filled + outstanding)
   cnt_t         outst_q, outst_d;        // allocated but not yet filled
   cnt_t         discard_q, discard_d;    // in-flight responses to drop
   logic         halted_q, halted_d;
   logic         stale_pend_q, stale_pend_d; // presented command predates a redirect

   fetch_entry_t entries_q [DEPTH];

   logic         cmd_accept;
   logic         alloc;
   logic         pop;
   logic         rsp_owned;
   logic         rsp_drop;
   logic         fill_en;
   logic         launch;
   logic         can_issue;
   addr_t        launch_pc;
   addr_t        redirect_pc_al;
   logic [CW:0]  budget;

   assign redirect_pc_al = align_word(redirect_pc);

   assign iBus_cmd_valid      = (state_q == FETCH_REQ);
   assign iBus_cmd_payload_pc = cmd_pc_q;

   // Filling is in order from head, so head is ready whenever some allocated
   // entry is no longer outstanding.
   assign out_valid = (count_q != outst_q);
   assign out_pc    = entries_q[head_q].pc;
   assign out_inst  = entries_q[head_q].inst;
   assign out_err   = entries_q[head_q].err;

   assign cmd_accept = (state_q == FETCH_REQ) && iBus_cmd_ready;
   assign alloc      = cmd_accept && !redirect_valid && !stale_pend_q;
   assign pop        = out_valid && out_ready && !redirect_valid;
   assign rsp_owned  = iBus_rsp_ready && ((discard_q != '0) || (outst_q != '0));
   assign rsp_drop   = iBus_rsp_ready && (redirect_valid || (discard_q != '0));
   assign fill_en    = iBus_rsp_ready && !rsp_drop && (outst_q != '0);

   // Queue pointers, occupancy, discard and halt bookkeeping.
   always_comb begin
      head_d       = head_q;
      fill_d       = fill_q;
      tail_d       = tail_q;
      count_d      = count_q;
      outst_d      = outst_q;
      discard_d    = discard_q;
      halted_d     = halted_q;
      stale_pend_d = stale_pend_q;

      if (redirect_valid) begin
         head_d    = tail_q;
         fill_d    = tail_q;
         count_d   = '0;
         outst_d   = '0;
         halted_d  = 1'b0;
         // Everything accepted and not yet returned becomes stale, including
         // a command accepted this very cycle; a response arriving now is one
         // of them and is removed from the total.
         discard_d = discard_q + outst_q + cnt_t'(cmd_accept) - cnt_t'(rsp_owned);
         stale_pend_d = (state_q == FETCH_REQ) && !iBus_cmd_ready;
      end else begin
         if (pop)     head_d = head_q + 1'b1;
         if (fill_en) fill_d = fill_q + 1'b1;
         if (alloc)   tail_d = tail_q + 1'b1;
         count_d   = count_q + cnt_t'(alloc) - cnt_t'(pop);
         outst_d   = outst_q + cnt_t'(alloc) - cnt_t'(fill_en);
         discard_d = discard_q
                   + cnt_t'(cmd_accept && stale_pend_q)
                   - cnt_t'(iBus_rsp_ready && (discard_q != '0));
         if (fill_en && iBus_rsp_err) halted_d = 1'b1;
         if (cmd_accept) stale_pend_d = 1'b0;
      end
   end

   // Command FSM. A new command is launched from IDLE or right after an
   // accept; stale in-flight responses share the DEPTH budget so discard
   // never exceeds its range.
   always_comb begin
      state_d    = state_q;
      cmd_pc_d   = cmd_pc_q;
      fetch_pc_d = fetch_pc_q;
      launch     = 1'b0;

      budget    = {1'b0, count_d} + {1'b0, discard_d};
      can_issue = (budget < DEPTH_W) && !halted_d;
      launch_pc = redirect_valid ? redirect_pc_al : fetch_pc_q;

      unique case (state_q)
         FETCH_IDLE: launch = 1'b1;
         FETCH_REQ: begin
            if (cmd_accept) begin
               launch = 1'b1;
            end else if (redirect_valid) begin
               // The pending command keeps its old PC; the redirect target
               // follows once it is accepted.
               fetch_pc_d = redirect_pc_al;
            end
         end
         default: launch = 1'b1;
      endcase

      if (launch) begin
         if (can_issue) begin
            state_d    = FETCH_REQ;
            cmd_pc_d   = launch_pc;
            fetch_pc_d = launch_pc + 32'd4;
         end else begin
            state_d    = FETCH_IDLE;
            fetch_pc_d = launch_pc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH_IDLE;
         cmd_pc_q     <= RESET_PC;
         fetch_pc_q   <= RESET_PC;
         head_q       <= '0;
         fill_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         outst_q      <= '0;
         discard_q    <= '0;
         halted_q     <= 1'b0;
         stale_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_pc_q     <= cmd_pc_d;
         fetch_pc_q   <= fetch_pc_d;
         head_q       <= head_d;
         fill_q       <= fill_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         outst_q      <= outst_d;
         discard_q    <= discard_d;
         halted_q     <= halted_d;
         stale_pend_q <= stale_pend_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         if (alloc) begin
            entries_q[tail_q].pc <= cmd_pc_q;
         end
         if (fill_en) begin
            entries_q[fill_q].inst <= iBus_rsp_inst;
            entries_q[fill_q].err  <= iBus_rsp_err;
         end
      end
   end

   // A response with nothing outstanding is a bus protocol violation.
   rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
      iBus_rsp_ready |-> ((discard_q != '0) || (outst_q != '0)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a bus responder with configurable
// latency, a queue-level model of expected decode output, and directed
// scenarios with hand-computed expectations.
module tb_ifetch_queue;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_pc;
   logic        rsp_ready;
   logic        rsp_err;
   logic [31:0] rsp_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_err;

   ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .iBus_cmd_valid      (cmd_valid),
      .iBus_cmd_ready      (cmd_ready),
      .iBus_cmd_payload_pc (cmd_pc),
      .iBus_rsp_ready      (rsp_ready),
      .iBus_rsp_err        (rsp_err),
      .iBus_rsp_inst       (rsp_inst),
      .redirect_valid      (redirect_valid),
      .redirect_pc         (redirect_pc),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_pc              (out_pc),
      .out_inst            (out_inst),
      .out_err             (out_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc + 32'h1300_0013;
   endfunction

   // Responder controls
   int          lat     = 1;
   bit          rsp_hold = 1'b0;
   bit          err_en  = 1'b0;
   logic [31:0] err_pc  = 32'h0;

   // Bus-side record of accepted commands awaiting a response
   logic [31:0] bq_pc[$];
   int          bq_due[$];

   // Model state
   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } infl_t;
   infl_t        mq[$];
   fetch_entry_t mb[$];
   bit           m_halt;
   logic [31:0]  exp_pc;
   bit           redir_after;
   logic [31:0]  redir_pc;
   bit           prev_pend;
   logic [31:0]  prev_pc;
   int           cyc = 0;

   // Observations used by directed checks
   int           n_acc, n_pop;
   logic [31:0]  acc_pc[$];
   logic [31:0]  pop_pc[$];
   logic [31:0]  pop_inst[$];
   logic         pop_err[$];

   always @(negedge clk) begin
      bit          acc, popm;
      infl_t       e;
      logic [31:0] rpc;
      cyc++;
      if (rst) begin
         rsp_ready = 1'b0; rsp_err = 1'b0; rsp_inst = '0;
         bq_pc.delete(); bq_due.delete(); mq.delete(); mb.delete();
         m_halt = 0; exp_pc = 32'h0; redir_after = 0; prev_pend = 0;
         n_acc = 0; n_pop = 0;
         acc_pc.delete(); pop_pc.delete(); pop_inst.delete(); pop_err.delete();
      end else begin
         // Compare DUT against model state after the last edge
         chk("out_valid", out_valid, (mb.size() != 0));
         if (mb.size() != 0) begin
            chk("out_pc", out_pc, mb[0].pc);
            chk("out_inst", out_inst, mb[0].inst);
            chk("out_err", out_err, mb[0].err);
         end
         if (prev_pend) begin
            chk("cmd_hold_valid", cmd_valid, 1);
            chk("cmd_hold_pc", cmd_pc, prev_pc);
         end else if (cmd_valid) begin
            chk("cmd_while_halted", m_halt, 0);
         end

         // Responder
         if (!rsp_hold && bq_pc.size() != 0 && bq_due[0] <= cyc) begin
            rpc = bq_pc.pop_front();
            void'(bq_due.pop_front());
            rsp_ready = 1'b1;
            rsp_inst  = inst_of(rpc);
            rsp_err   = err_en && (rpc == err_pc);
         end else begin
            rsp_ready = 1'b0; rsp_err = 1'b0; rsp_inst = '0;
         end

         // Advance model with what the coming edge will see
         acc  = cmd_valid && cmd_ready;
         popm = (mb.size() != 0) && out_ready && !redirect_valid;
         if (popm) begin
            pop_pc.push_back(mb[0].pc);
            pop_inst.push_back(mb[0].inst);
            pop_err.push_back(mb[0].err);
            void'(mb.pop_front());
            n_pop++;
         end
         if (rsp_ready) begin
            if (mq.size() == 0) begin
               chk("rsp_owner", 0, 1);
            end else begin
               e = mq.pop_front();
               if (!e.stale && !redirect_valid) begin
                  mb.push_back('{pc: e.pc, inst: rsp_inst, err: rsp_err});
                  if (rsp_err) m_halt = 1;
               end
            end
         end
         if (acc) begin
            chk("acc_pc", cmd_pc, exp_pc);
            n_acc++;
            acc_pc.push_back(cmd_pc);
            bq_pc.push_back(cmd_pc);
            bq_due.push_back(cyc + lat);
            mq.push_back('{pc: cmd_pc, stale: (redirect_valid || redir_after)});
            if (redir_after) begin
               exp_pc = redir_pc;
               redir_after = 0;
            end else begin
               exp_pc = exp_pc + 32'd4;
            end
         end
         if (redirect_valid) begin
            foreach (mq[i]) mq[i].stale = 1;
            mb.delete();
            m_halt = 0;
            if (cmd_valid && !cmd_ready) begin
               redir_after = 1;
               redir_pc = {redirect_pc[31:2], 2'b00};
            end else begin
               redir_after = 0;
               exp_pc = {redirect_pc[31:2], 2'b00};
            end
         end
         chk("cap", ((mb.size() + mq.size()) <= 4), 1);
         prev_pend = cmd_valid && !cmd_ready;
         prev_pc   = cmd_pc;
      end
   end

   task automatic do_reset();
      #2;
      rst = 1'b1;
      cmd_ready = 1'b1; out_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;
      rsp_hold = 0; err_en = 0; lat = 1;
      @(negedge clk); #1;
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_pc", cmd_pc, 32'h0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_inst", out_inst, 32'h0);
      chk("rst_out_err", out_err, 0);
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      cmd_ready = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;

      // 1: streaming, latency 1, decode always ready
      do_reset();
      repeat (5) @(posedge clk);
      cycles(1);
      n0 = n_pop;
      cycles(10);
      chk("t1_throughput", n_pop - n0, 10);
      chk("t1_pc0", pop_pc[0], 32'h0);
      chk("t1_pc1", pop_pc[1], 32'h4);
      chk("t1_pc2", pop_pc[2], 32'h8);
      chk("t1_pc5", pop_pc[5], 32'h14);
      chk("t1_inst2", pop_inst[2], 32'h1300_001B);

      // 2: decode stalled, fill to DEPTH, then a single pop
      do_reset();
      out_ready = 1'b0;
      cycles(12);
      chk("t2_acc4", n_acc, 4);
      chk("t2_cmd_low", cmd_valid, 0);
      chk("t2_out_valid", out_valid, 1);
      @(posedge clk); #2 out_ready = 1'b1;
      @(posedge clk); #2 out_ready = 1'b0;
      cycles(8);
      chk("t2_pop1", n_pop, 1);
      chk("t2_acc5", n_acc, 5);
      chk("t2_pc10", acc_pc[4], 32'h10);
      chk("t2_cmd_low2", cmd_valid, 0);

      // 3: command stalled by the bus
      do_reset();
      cmd_ready = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         cycles(1);
         chk("t3_valid", cmd_valid, 1);
         chk("t3_pc", cmd_pc, 32'h0);
      end
      @(posedge clk); #2 cmd_ready = 1'b1;
      cycles(4);
      chk("t3_acc0", acc_pc[0], 32'h0);
      chk("t3_acc1", acc_pc[1], 32'h4);

      // 4: redirect with 3 responses outstanding and a command pending
      do_reset();
      rsp_hold = 1; cmd_ready = 1'b0;
      @(posedge clk); #2 cmd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 cmd_ready = 1'b0;
      @(posedge clk); #2 redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
      @(posedge clk); #2 redirect_valid = 1'b0; cmd_ready = 1'b1; rsp_hold = 0;
      cycles(1);
      chk("t4_empty", out_valid, 0);
      cycles(30);
      chk("t4_acc3", acc_pc[3], 32'hC);
      chk("t4_acc4", acc_pc[4], 32'h100);
      chk("t4_first", pop_pc[0], 32'h100);
      chk("t4_second", pop_pc[1], 32'h104);

      // 5: bus error halts fetch until redirect
      do_reset();
      err_en = 1; err_pc = 32'h8;
      cycles(15);
      chk("t5_acc", n_acc, 4);
      chk("t5_cmd_low", cmd_valid, 0);
      chk("t5_err_pc", pop_pc[2], 32'h8);
      chk("t5_err", pop_err[2], 1);
      chk("t5_ok_err", pop_err[3], 0);
      chk("t5_pc3", pop_pc[3], 32'hC);
      err_en = 0;
      @(posedge clk); #2 redirect_valid = 1'b1; redirect_pc = 32'h40;
      @(posedge clk); #2 redirect_valid = 1'b0;
      cycles(10);
      chk("t5_resume_acc", acc_pc[4], 32'h40);
      chk("t5_resume_pop", pop_pc[4], 32'h40);
      chk("t5_resume_err", pop_err[4], 0);

      // 6: redirect coinciding with accept, response and pop
      do_reset();
      cycles(8);
      n0 = n_pop;
      @(posedge clk); #2 redirect_valid = 1'b1; redirect_pc = 32'h200;
      @(posedge clk); #2 redirect_valid = 1'b0;
      cycles(12);
      chk("t6_first", pop_pc[n0], 32'h200);
      chk("t6_second", pop_pc[n0 + 1], 32'h204);
      chk("t6_third", pop_pc[n0 + 2], 32'h208);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
